// File: rtl/cfg_dma_pkg.sv
// cfg_dma_pkg: shared types and constants for the config DMA read/write responders.
package cfg_dma_pkg;
  typedef enum logic [1:0] {RSP_IDLE, RSP_ISSUE, RSP_DRAIN} rsp_state_t;
  localparam int CFG_MAX_BYTES = 4096;
  localparam int BEAT_BYTES = 8;
  localparam logic [7:0] TAG_CONFIG = 8'h00;
  // Length 0 stands for a full 4 KB request; result is always 1..512 beats.
  function automatic logic [9:0] calc_beats(input logic [11:0] len);
    logic [12:0] bytes;
    bytes = (len == '0) ? 13'(CFG_MAX_BYTES) : {1'b0, len};
    return 10'((bytes + 13'(BEAT_BYTES - 1)) / 13'(BEAT_BYTES));
  endfunction
endpackage

// File: rtl/cfg_rd_credit_cnt.sv
// cfg_rd_credit_cnt: outstanding-read counter; simultaneous inc/dec leaves it unchanged.
module cfg_rd_credit_cnt #(
  parameter int MAX = 8,
  parameter int W = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full
);
  logic up, dn;
  assign full = count == W'(MAX);
  assign up = inc && (!full || dec);
  assign dn = dec && count != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (up != dn) count <= up ? count + W'(1) : count - W'(1);
endmodule

// File: rtl/config_rd_responder.sv
// config_rd_responder: serves config read requests from an in-order 64-bit memory port
// and owns the config-done / done-ack handshake.
module config_rd_responder import cfg_dma_pkg::*; #(
  parameter int MAX_OUTSTANDING = 8,
  parameter logic [7:0] RSP_TAG = TAG_CONFIG
) (
  input  logic        i_pcie_clk,
  input  logic        i_rst_n,
  input  logic        config_rd_req_i,
  input  logic [31:0] config_rd_req_addr_i,
  input  logic [11:0] config_rd_req_len_i,
  output logic        config_rd_req_ack_o,
  output logic [63:0] o_config_data,
  output logic        o_config_data_valid,
  output logic [7:0]  dma_tag_o,
  output logic        mem_rd_req_o,
  output logic [28:0] mem_rd_addr_o,
  input  logic        mem_rd_gnt_i,
  input  logic [63:0] mem_rd_data_i,
  input  logic        mem_rd_valid_i,
  input  logic        config_done_i,
  input  logic        sw_done_clr_i,
  output logic        config_done_ack_o,
  output logic        o_busy,
  output logic        o_err
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  rsp_state_t state, state_nx;
  logic [9:0] beats, issued, returned;
  logic [CW-1:0] outstanding;
  logic full, empty, accept, take, done_q, done_pend;
  cfg_rd_credit_cnt #(.MAX(MAX_OUTSTANDING), .W(CW)) u_credit (
    .clk(i_pcie_clk),
    .rst_n(i_rst_n),
    .inc(accept),
    .dec(mem_rd_valid_i),
    .count(outstanding),
    .full(full)
  );
  assign empty = outstanding == '0;
  assign take = state == RSP_IDLE && config_rd_req_i;
  assign mem_rd_req_o = state == RSP_ISSUE && issued < beats && !full;
  assign accept = mem_rd_req_o && mem_rd_gnt_i;
  assign o_busy = state != RSP_IDLE;
  assign dma_tag_o = o_config_data_valid ? RSP_TAG : 8'h00;
  always_comb begin
    state_nx = state;
    case (state)
      RSP_IDLE:  state_nx = config_rd_req_i ? RSP_ISSUE : RSP_IDLE;
      RSP_ISSUE: state_nx = (accept && issued == beats - 10'd1) ? RSP_DRAIN : RSP_ISSUE;
      RSP_DRAIN: state_nx = (returned == beats) ? RSP_IDLE : RSP_DRAIN;
      default:   state_nx = RSP_IDLE;
    endcase
  end
  always_ff @(posedge i_pcie_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RSP_IDLE;
      config_rd_req_ack_o <= 1'b0;
      mem_rd_addr_o <= '0;
      beats <= '0;
      issued <= '0;
      returned <= '0;
      o_err <= 1'b0;
      o_config_data <= '0;
      o_config_data_valid <= 1'b0;
    end else begin
      state <= state_nx;
      config_rd_req_ack_o <= take;
      if (take) begin
        mem_rd_addr_o <= config_rd_req_addr_i[31:3];
        beats <= calc_beats(config_rd_req_len_i);
        issued <= '0;
        returned <= '0;
      end else begin
        if (accept) begin
          mem_rd_addr_o <= mem_rd_addr_o + 29'd1;
          issued <= issued + 10'd1;
        end
        if (mem_rd_valid_i && !empty) returned <= returned + 10'd1;
      end
      // Misaligned start and data with nothing outstanding are both sticky errors.
      if ((take && config_rd_req_addr_i[2:0] != 3'd0) || (mem_rd_valid_i && empty)) o_err <= 1'b1;
      o_config_data_valid <= mem_rd_valid_i;
      if (mem_rd_valid_i) o_config_data <= mem_rd_data_i;
    end
  end
  always_ff @(posedge i_pcie_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_q <= 1'b0;
      done_pend <= 1'b0;
      config_done_ack_o <= 1'b0;
    end else begin
      done_q <= config_done_i;
      if (config_done_ack_o && !config_done_i) begin
        config_done_ack_o <= 1'b0;
        done_pend <= 1'b0;
      end else begin
        if (config_done_i && !done_q) done_pend <= 1'b1;
        if (sw_done_clr_i && done_pend) config_done_ack_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_config_rd_responder.sv
// tb_config_rd_responder: directed bench with an in-order memory model and a requester model.
module tb_config_rd_responder;
  logic clk = 0, rst_n = 0, req = 0, gnt = 0, mvalid = 0, done = 0, clr = 0;
  logic [31:0] req_addr = 0;
  logic [11:0] req_len = 0;
  logic [63:0] mdata = 0, cdata;
  logic ack, cvalid, mreq, done_ack, busy, err;
  logic [7:0] tag;
  logic [28:0] maddr, exp_word, first_addr, last_addr;
  logic gnt_en = 0, ret_en = 0;
  logic [28:0] pend[$];
  int checks = 0, errors = 0;
  int grants = 0, beats_seen = 0, acks = 0, addr_bad = 0, beat_bad = 0, ncyc = 0, req_cyc = 0, ack_cyc = 0;

  config_rd_responder dut (
    .i_pcie_clk(clk), .i_rst_n(rst_n),
    .config_rd_req_i(req), .config_rd_req_addr_i(req_addr), .config_rd_req_len_i(req_len),
    .config_rd_req_ack_o(ack), .o_config_data(cdata), .o_config_data_valid(cvalid), .dma_tag_o(tag),
    .mem_rd_req_o(mreq), .mem_rd_addr_o(maddr), .mem_rd_gnt_i(gnt), .mem_rd_data_i(mdata),
    .mem_rd_valid_i(mvalid), .config_done_i(done), .sw_done_clr_i(clr),
    .config_done_ack_o(done_ack), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dfn(input logic [28:0] w);
    return {3'b101, w, 3'b010, ~w};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    logic sv;
    logic [63:0] sd;
    if (mreq && gnt) begin
      if (grants == 0) first_addr = maddr;
      last_addr = maddr;
      if (maddr !== exp_word) addr_bad++;
      exp_word = exp_word + 29'd1;
      pend.push_back(maddr);
      grants++;
    end
    sv = mvalid;
    sd = mdata;
    @(posedge clk); #1;
    ncyc++;
    if (sv) begin
      beats_seen++;
      if (cvalid !== 1'b1 || cdata !== sd || tag !== 8'h00) beat_bad++;
    end else if (cvalid !== 1'b0 || tag !== 8'h00) beat_bad++;
    if (ack) begin
      acks++;
      ack_cyc = ncyc;
      req = 0;
    end
    gnt = gnt_en;
    if (ret_en && pend.size() > 0) begin
      mvalid = 1;
      mdata = dfn(pend.pop_front());
    end else mvalid = 0;
  endtask

  task automatic start(input logic [31:0] a, input logic [11:0] l);
    req = 1;
    req_addr = a;
    req_len = l;
    exp_word = a[31:3];
    grants = 0;
    beats_seen = 0;
    acks = 0;
    addr_bad = 0;
    beat_bad = 0;
    req_cyc = ncyc;
  endtask

  task automatic wait_idle(input int need_acks);
    int n = 0;
    while (!(acks >= need_acks && !busy) && n < 3000) begin
      cyc();
      n++;
    end
    chk("idle_timeout", 64'(n < 3000), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_mreq", 64'(mreq), 64'd0);
    chk("rst_maddr", 64'(maddr), 64'd0);
    chk("rst_valid_tag", {55'd0, cvalid, tag}, 64'd0);
    chk("rst_err_dack", {62'd0, err, done_ack}, 64'd0);
    rst_n = 1;
    cyc();
    // full 4 KB request
    gnt_en = 1;
    ret_en = 1;
    start(32'h1000, 12'd0);
    wait_idle(1);
    chk("t1_acks", 64'(acks), 64'd1);
    chk("t1_ack_lat", 64'(ack_cyc - req_cyc), 64'd1);
    chk("t1_grants", 64'(grants), 64'd512);
    chk("t1_first", 64'(first_addr), 64'h200);
    chk("t1_last", 64'(last_addr), 64'h3FF);
    chk("t1_beats", 64'(beats_seen), 64'd512);
    chk("t1_addr_bad", 64'(addr_bad), 64'd0);
    chk("t1_beat_bad", 64'(beat_bad), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    // length rounding
    start(32'h100, 12'd13);
    wait_idle(1);
    chk("t2_len13_grants", 64'(grants), 64'd2);
    chk("t2_len13_beats", 64'(beats_seen), 64'd2);
    start(32'h200, 12'd8);
    wait_idle(1);
    chk("t2_len8_grants", 64'(grants), 64'd1);
    chk("t2_len8_beats", 64'(beats_seen), 64'd1);
    start(32'h300, 12'd1);
    wait_idle(1);
    chk("t2_len1_grants", 64'(grants), 64'd1);
    chk("t2_len1_beats", 64'(beats_seen), 64'd1);
    chk("t2_beat_bad", 64'(beat_bad), 64'd0);
    chk("t2_err", 64'(err), 64'd0);
    // credit limit, then one return while full
    ret_en = 0;
    start(32'h2000, 12'd0);
    repeat (22) cyc();
    chk("t3_grants", 64'(grants), 64'd8);
    chk("t3_stall", 64'(mreq), 64'd0);
    mvalid = 1;
    mdata = dfn(pend.pop_front());
    cyc();
    chk("t4_grants_hold", 64'(grants), 64'd8);
    chk("t4_req_next", 64'(mreq), 64'd1);
    cyc();
    chk("t4_grants_refill", 64'(grants), 64'd9);
    chk("t4_full_again", 64'(mreq), 64'd0);
    ret_en = 1;
    wait_idle(1);
    chk("t3_total_grants", 64'(grants), 64'd512);
    chk("t3_total_beats", 64'(beats_seen), 64'd512);
    chk("t3_addr_bad", 64'(addr_bad), 64'd0);
    chk("t3_beat_bad", 64'(beat_bad), 64'd0);
    // second request held during DRAIN; misaligned first request
    ret_en = 0;
    start(32'h1004, 12'd16);
    repeat (6) cyc();
    chk("t5_first_grants", 64'(grants), 64'd2);
    chk("t5_start_word", 64'(first_addr), 64'h200);
    req = 1;
    req_addr = 32'h3000;
    req_len = 12'd8;
    exp_word = 29'h600;
    grants = 0;
    repeat (10) cyc();
    chk("t5_no_ack_drain", 64'(acks), 64'd1);
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_err", 64'(err), 64'd1);
    ret_en = 1;
    wait_idle(2);
    chk("t5_second_ack", 64'(acks), 64'd2);
    chk("t5_second_grants", 64'(grants), 64'd1);
    chk("t5_second_addr", 64'(first_addr), 64'h600);
    chk("t5_beat_bad", 64'(beat_bad), 64'd0);
    // done handshake
    done = 1;
    repeat (3) cyc();
    chk("t6_ack_before_clr", 64'(done_ack), 64'd0);
    clr = 1;
    cyc();
    clr = 0;
    chk("t6_ack_set", 64'(done_ack), 64'd1);
    repeat (4) cyc();
    chk("t6_ack_held", 64'(done_ack), 64'd1);
    done = 0;
    cyc();
    chk("t6_ack_drop", 64'(done_ack), 64'd0);
    clr = 1;
    cyc();
    clr = 0;
    cyc();
    chk("t6_clr_ignored", 64'(done_ack), 64'd0);
    // async reset mid-ISSUE, stale returns afterwards
    ret_en = 0;
    start(32'h0, 12'd0);
    repeat (6) cyc();
    rst_n = 0;
    req = 0;
    gnt_en = 0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_mreq", 64'(mreq), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_ack_valid", {62'd0, ack, cvalid}, 64'd0);
    repeat (2) cyc();
    rst_n = 1;
    ret_en = 1;
    beat_bad = 0;
    repeat (10) cyc();
    chk("t6_spurious_err", 64'(err), 64'd1);
    chk("t6_spurious_busy", 64'(busy), 64'd0);
    chk("t6_spurious_fwd", 64'(beat_bad), 64'd0);
    gnt_en = 1;
    start(32'h40, 12'd8);
    wait_idle(1);
    chk("t6_after_grants", 64'(grants), 64'd1);
    chk("t6_after_beats", 64'(beats_seen), 64'd1);
    chk("t6_after_addr", 64'(first_addr), 64'h8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
